// File: rtl/timed_settings_sched.sv
// Timed settings-bus scheduler: FIFO of {timed,time,addr,data}; head issues on hit, set_stb 3 cycles after an idle push.
// Backpressure: cmd_ready is registered, low when full or after flush; at most one strobe every 3 cycles.
module sched_fifo #(
  parameter int W   = 1,
  parameter int DL2 = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wr_dat,
  output logic [W-1:0]   rd_dat,
  output logic [DL2:0]   count
);
  localparam int N = 2**DL2;

  logic [W-1:0]   mem [N];
  logic [DL2-1:0] wr_ptr;
  logic [DL2-1:0] rd_ptr;

  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module timed_settings_sched #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           vita_time,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_timed,
  input  logic [63:0]           cmd_time,
  input  logic [7:0]            cmd_addr,
  input  logic [31:0]           cmd_data,
  input  logic                  flush,
  output logic                  set_stb,
  output logic [7:0]            set_addr,
  output logic [31:0]           set_data,
  output logic                  late,
  output logic [15:0]           late_count,
  output logic [DEPTH_LOG2:0]   occupancy
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  typedef struct packed {
    logic        timed;
    logic [63:0] t;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t state, state_nxt;
  cmd_t   in_cmd, head;
  logic   push, pop, hit, is_late, fire;
  logic [DEPTH_LOG2:0] occ_nxt;

  assign in_cmd  = '{timed: cmd_timed, t: cmd_time, addr: cmd_addr, data: cmd_data};
  assign push    = cmd_valid & cmd_ready & ~flush;
  assign pop     = (state == S_ISSUE) & ~flush;
  assign hit     = ~head.timed | (vita_time >= head.t);
  assign is_late = head.timed & (vita_time > head.t + 64'd1);
  assign fire    = (state == S_WAIT) & hit & ~flush;

  sched_fifo #(.W($bits(cmd_t)), .DL2(DEPTH_LOG2)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push),
    .pop    (pop),
    .wr_dat (in_cmd),
    .rd_dat (head),
    .count  (occupancy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (occupancy != '0) state_nxt = S_WAIT;
      S_WAIT:  if (hit) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Ready is registered from the post-edge occupancy so a full FIFO never accepts.
  always_comb begin
    occ_nxt = occupancy;
    if (flush)             occ_nxt = '0;
    else if (push && !pop) occ_nxt = occupancy + 1'b1;
    else if (pop && !push) occ_nxt = occupancy - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      set_stb    <= 1'b0;
      set_addr   <= '0;
      set_data   <= '0;
      late       <= 1'b0;
      late_count <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= ~flush & (occ_nxt != FULL_CNT);
      set_stb   <= fire;
      late      <= fire & is_late;
      if (fire) begin
        set_addr <= head.addr;
        set_data <= head.data;
      end
      if (fire && is_late && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_timed_settings_sched.sv
module tb_timed_settings_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] vita_time = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_timed = 1'b0;
  logic [63:0] cmd_time = '0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        flush = 1'b0;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        late;
  logic [15:0] late_count;
  logic [2:0]  occupancy;

  timed_settings_sched #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .vita_time(vita_time),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_timed(cmd_timed),
    .cmd_time(cmd_time), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .flush(flush), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .late(late), .late_count(late_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          timed;
    logic [63:0] t;
    logic [7:0]  a;
    logic [31:0] d;
  } tcmd_t;

  int          vectors = 0;
  int          miscompares = 0;
  bit          vita_run = 1'b0;
  bit          acc;
  logic [63:0] edge_vita;
  int          cyc = 0;
  int          exp_lc = 0;

  // Advance one edge; acc records whether a command handshake happened on it.
  task automatic tick();
    acc = cmd_valid && cmd_ready && !flush;
    @(posedge clk);
    #1;
    edge_vita = vita_time;
    if (vita_run) vita_time = vita_time + 64'd1;
    cyc++;
  endtask

  task automatic drive(input bit timed, input logic [63:0] t, input logic [7:0] a, input logic [31:0] d);
    cmd_timed = timed; cmd_time = t; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors++;
    if ({set_stb, late, cmd_ready} !== 3'b000 || set_addr !== 8'h00 || set_data !== 32'h0 ||
        late_count !== 16'h0 || occupancy !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_vals stb=%0b late=%0b rdy=%0b addr=%h data=%h lc=%0d occ=%0d required all zero",
               set_stb, late, cmd_ready, set_addr, set_data, late_count, occupancy);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_rst got=%b want=1", cmd_ready); end
  endtask

  task automatic test_immediate();
    drive(1'b0, 64'd0, 8'h05, 32'hDEADBEEF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      vectors++;
      if (set_stb !== (i == 3)) begin miscompares++; $display("FAIL imm_stb cycle=%0d got=%b want=%b", i, set_stb, (i == 3)); end
      if (i == 3) begin
        vectors++;
        if (set_addr !== 8'h05 || set_data !== 32'hDEADBEEF || late !== 1'b0) begin
          miscompares++; $display("FAIL imm_data got=%h/%h late=%b want=05/deadbeef late=0", set_addr, set_data, late);
        end
      end
      tick();
    end
    vectors++;
    if (set_addr !== 8'h05 || set_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL imm_hold got=%h/%h want=05/deadbeef", set_addr, set_data);
    end
  endtask

  task automatic test_timed();
    int seen = 0;
    vita_time = 64'd1000; vita_run = 1'b1;
    drive(1'b1, 64'd1010, 8'h33, 32'h12345678);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (set_stb) begin
        seen++;
        vectors++;
        if (edge_vita !== 64'd1010 || late !== 1'b0 || set_addr !== 8'h33) begin
          miscompares++; $display("FAIL timed_issue vita=%0d late=%b addr=%h want vita=1010 late=0 addr=33", edge_vita, late, set_addr);
        end
      end
      tick();
    end
    vita_run = 1'b0;
    vectors++;
    if (seen != 1) begin miscompares++; $display("FAIL timed_count got=%0d want=1", seen); end
  endtask

  task automatic test_late();
    int seen = 0;
    vita_time = 64'd5000;
    drive(1'b1, 64'd100, 8'h44, 32'hCAFEF00D);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (set_stb) begin
        seen++;
        vectors++;
        if (late !== 1'b1 || set_data !== 32'hCAFEF00D) begin
          miscompares++; $display("FAIL late_pulse late=%b data=%h want late=1 data=cafef00d", late, set_data);
        end
      end else if (late !== 1'b0) begin
        vectors++; miscompares++; $display("FAIL late_stray late=%b want=0", late);
      end
      tick();
    end
    exp_lc = 1;
    vectors++;
    if (seen != 1 || late_count !== 16'(exp_lc)) begin
      miscompares++; $display("FAIL late_count strobes=%0d lc=%0d want strobes=1 lc=%0d", seen, late_count, exp_lc);
    end
  endtask

  task automatic test_full_order();
    tcmd_t cmds[5];
    int    stb_cyc[$];
    int    k = 0;
    vita_time = 64'd0;
    for (int i = 0; i < 5; i++) begin
      cmds[i].timed = (i == 0);
      cmds[i].t     = (i == 0) ? 64'h1_0000_0000 : 64'd0;
      cmds[i].a     = 8'h10 + 8'(i);
      cmds[i].d     = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      drive(cmds[i].timed, cmds[i].t, cmds[i].a, cmds[i].d);
      tick();
      vectors++;
      if (acc !== 1'b1) begin miscompares++; $display("FAIL full_push idx=%0d accepted=%b want=1", i, acc); end
    end
    drive(cmds[4].timed, cmds[4].t, cmds[4].a, cmds[4].d);
    vectors++;
    if (cmd_ready !== 1'b0 || occupancy !== 3'd4) begin
      miscompares++; $display("FAIL full_state rdy=%b occ=%0d want rdy=0 occ=4", cmd_ready, occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (acc !== 1'b0 || occupancy !== 3'd4 || set_stb !== 1'b0) begin
        miscompares++; $display("FAIL full_hold accepted=%b occ=%0d stb=%b want 0/4/0", acc, occupancy, set_stb);
      end
    end
    cmd_valid = 1'b0;
    vita_time = 64'h1_0000_0000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (set_stb) begin
        stb_cyc.push_back(cyc);
        vectors++;
        if (k > 3 || set_addr !== cmds[k].a || set_data !== cmds[k].d || late !== 1'b0) begin
          miscompares++; $display("FAIL full_order idx=%0d got=%h/%h late=%b", k, set_addr, set_data, late);
        end
        k++;
      end
    end
    vectors++;
    if (k != 4) begin miscompares++; $display("FAIL full_issued got=%0d want=4", k); end
    for (int i = 1; i < stb_cyc.size(); i++) begin
      vectors++;
      if (stb_cyc[i] - stb_cyc[i-1] != 3) begin
        miscompares++; $display("FAIL full_spacing idx=%0d got=%0d want=3", i, stb_cyc[i] - stb_cyc[i-1]);
      end
    end
  endtask

  task automatic test_flush();
    vita_time = 64'd2000;
    drive(1'b1, 64'd3000, 8'h20, 32'h0BADF00D);
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    vita_time = 64'd3000;
    flush = 1'b1;
    drive(1'b0, 64'd0, 8'h21, 32'h11111111);
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    vectors++;
    if (set_stb !== 1'b0 || late !== 1'b0 || occupancy !== 3'd0 || cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_cycle stb=%b late=%b occ=%0d rdy=%b want 0/0/0/0", set_stb, late, occupancy, cmd_ready);
    end
    tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (set_stb !== 1'b0 || occupancy !== 3'd0) begin
        miscompares++; $display("FAIL flush_quiet stb=%b occ=%0d want 0/0", set_stb, occupancy);
      end
      tick();
    end
  endtask

  task automatic test_random();
    tcmd_t sb[$];
    tcmd_t cur;
    tcmd_t exp;
    int    sent = 0;
    int    model_occ = 0;
    bit    pop_pending = 1'b0;
    bit    exp_late;
    vita_time = 64'd10000; vita_run = 1'b1;
    for (int c = 0; c < 3000 && (sent < 40 || sb.size() > 0 || pop_pending); c++) begin
      if (sent < 40 && !cmd_valid && ($urandom % 3) == 0) begin
        cur.timed = $urandom % 2;
        cur.t     = vita_time + 64'($urandom_range(0, 40)) - 64'd20;
        cur.a     = 8'($urandom);
        cur.d     = $urandom;
        drive(cur.timed, cur.t, cur.a, cur.d);
      end
      tick();
      if (acc) begin
        sb.push_back(cur); model_occ++; sent++; cmd_valid = 1'b0;
      end
      if (pop_pending) begin model_occ--; pop_pending = 1'b0; end
      if (set_stb) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL rnd_spurious addr=%h data=%h want no strobe", set_addr, set_data);
        end else begin
          exp = sb.pop_front();
          exp_late = exp.timed && (edge_vita > exp.t + 64'd1);
          if (exp_late && exp_lc < 65535) exp_lc++;
          if (set_addr !== exp.a || set_data !== exp.d || late !== exp_late ||
              late_count !== 16'(exp_lc) || (exp.timed && edge_vita < exp.t)) begin
            miscompares++;
            $display("FAIL rnd_issue got=%h/%h late=%b lc=%0d vita=%0d want=%h/%h late=%b lc=%0d t=%0d",
                     set_addr, set_data, late, late_count, edge_vita, exp.a, exp.d, exp_late, exp_lc, exp.t);
          end
          pop_pending = 1'b1;
        end
      end else if (late !== 1'b0) begin
        vectors++; miscompares++; $display("FAIL rnd_late_stray late=%b want=0", late);
      end
      vectors++;
      if (occupancy !== 3'(model_occ) || cmd_ready !== (model_occ != 4)) begin
        miscompares++; $display("FAIL rnd_occ occ=%0d rdy=%b want occ=%0d rdy=%b", occupancy, cmd_ready, model_occ, model_occ != 4);
      end
    end
    vita_run = 1'b0; cmd_valid = 1'b0;
    vectors++;
    if (sent != 40 || sb.size() != 0) begin
      miscompares++; $display("FAIL rnd_drain sent=%0d left=%0d want sent=40 left=0", sent, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    vita_time = 64'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'd0, 8'h50 + 8'(i), 32'h5000_0000 + 32'(i));
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (set_stb) seen = 1'b1;
      else tick();
    end
    vectors++;
    if (!seen || occupancy !== 3'd3) begin
      miscompares++; $display("FAIL rstmid_setup stb_seen=%b occ=%0d want 1/3", seen, occupancy);
    end
    #2 rst = 1'b1;
    #1;
    exp_lc = 0;
    vectors++;
    if ({set_stb, late, cmd_ready} !== 3'b000 || set_addr !== 8'h00 || set_data !== 32'h0 ||
        late_count !== 16'h0 || occupancy !== 3'd0) begin
      miscompares++;
      $display("FAIL rstmid_vals stb=%b late=%b rdy=%b addr=%h data=%h lc=%0d occ=%0d required all zero",
               set_stb, late, cmd_ready, set_addr, set_data, late_count, occupancy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (set_stb !== 1'b0 || occupancy !== 3'd0) begin
        miscompares++; $display("FAIL rstmid_quiet stb=%b occ=%0d want 0/0", set_stb, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_timed();
    test_late();
    test_full_order();
    test_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timed_settings_sched.md
TIMED_SETTINGS_SCHED -- requirements
Module: timed_settings_sched

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, meaning log2 of command queue depth (4 entries).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port vita_time  input  64  current device time in ticks.
REQ-005 SHALL have port cmd_valid  input  1  command present on cmd_* inputs.
REQ-006 SHALL have port cmd_ready  output  1  queue can accept a command.
REQ-007 SHALL have port cmd_timed  input  1  1 = issue at cmd_time; 0 = issue immediately.
REQ-008 SHALL have port cmd_time  input  64  issue time in ticks.
REQ-009 SHALL have port cmd_addr  input  8  settings bus address.
REQ-010 SHALL have port cmd_data  input  32  settings bus data.
REQ-011 SHALL have port flush  input  1  discard all queued and pending commands.
REQ-012 SHALL have port set_stb  output  1  settings bus strobe, one cycle per command.
REQ-013 SHALL have port set_addr  output  8  settings bus address.
REQ-014 SHALL have port set_data  output  32  settings bus data.
REQ-015 SHALL have port late  output  1  pulse with set_stb when a timed command issues after its time.
REQ-016 SHALL have port late_count  output  16  saturating count of late issues.
REQ-017 SHALL have port occupancy  output  DEPTH_LOG2+1  number of queued entries.

Function
REQ-018 SHALL accept a command into a FIFO of 2^DEPTH_LOG2 entries {timed,time,addr,data} on a rising edge with cmd_valid & cmd_ready.
REQ-019 SHALL register cmd_ready as: 1 when FIFO not full and flush low; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-020 SHALL run FSM IDLE -> WAIT when FIFO non-empty; WAIT -> ISSUE when hit; ISSUE -> IDLE unconditionally.
REQ-021 SHALL define hit = ~head.timed | (vita_time >= head.time), 64-bit unsigned compare, no wrap handling.
REQ-022 SHALL in ISSUE drive set_stb=1 for exactly one cycle with set_addr/set_data = head entry and pop the head in that cycle.
REQ-023 SHALL hold set_addr/set_data at last issued values when set_stb=0.
REQ-024 SHALL, for an immediate command accepted in cycle 0 into an empty idle block, assert set_stb in cycle 3.
REQ-025 SHALL, for a timed command at WAIT head, assert set_stb the cycle after the first cycle where vita_time >= head.time.
REQ-026 SHALL assert late with set_stb when head.timed=1 and vita_time > head.time+1 in the WAIT cycle that hit; the command SHALL still issue.
REQ-027 SHALL increment late_count on each late pulse, saturating at 16'hFFFF.
REQ-028 SHALL issue commands strictly in FIFO order; a future-timed head blocks later immediate entries.
REQ-029 SHALL on flush=1 empty the FIFO, force FSM to IDLE, suppress set_stb/late that cycle, and drop any same-cycle cmd_valid.
REQ-030 SHALL give flush priority over a WAIT -> ISSUE transition in the same cycle (no strobe generated).
REQ-031 SHALL update occupancy the cycle after push/pop; simultaneous push and pop leave it unchanged.
REQ-032 SHALL sustain at most one command per 3 cycles (IDLE/WAIT/ISSUE).

Reset
REQ-033 SHALL on rst asynchronously set FSM=IDLE, FIFO empty, occupancy=0, set_stb=0, set_addr=0, set_data=0, late=0, late_count=0, cmd_ready=0.
REQ-034 SHALL set cmd_ready=1 in the first cycle after rst deasserts.
REQ-035 SHALL, on rst asserted mid-ISSUE, drop the strobe immediately and discard the queued command.

Verification
REQ-036 Immediate: push {timed=0,addr=8'h05,data=32'hDEADBEEF} cycle 0 -> set_stb=1 only in cycle 3, set_addr=05, set_data=DEADBEEF.
REQ-037 Timed: vita_time ramps from 1000, push time=1010 -> set_stb the cycle after vita_time=1010, late=0.
REQ-038 Late: vita_time=5000, push time=100 -> issues, late=1 with set_stb, late_count=1.
REQ-039 Full/order: push 5 commands with head time far future -> cmd_ready=0 after 4, occupancy=4; on hit all 4 issue in order, 3 cycles apart.
REQ-040 Flush: flush in cycle WAIT hits -> no set_stb, occupancy=0 next cycle, cmd_ready=1 after flush deasserts.
REQ-041 Reset mid-operation: assert rst with 3 queued -> all outputs to reset values immediately, no strobe after release.
